// File: rtl/strided_address_generator.sv
`default_nettype none
// ============================================================================
// Module   : strided_address_generator
// Purpose  : Walks a 2-D strided region (lineCount lines of lineBeats beats,
//            line starts lineStride bytes apart) and emits AXI address-channel
//            INCR bursts of at most MAX_AxLEN+1 beats. Each burst gets a
//            sequential ID starting at 0 for every job.
// Ports    : aclk/reset        - clock, synchronous active-high reset
//            start/done        - job request (sampled while idle) / idle flag
//            startAddr, lineStride, lineBeats, lineCount - job description
//            axid..axprot      - AXI AW/AR address-channel payload
//            axvalid/axready   - AXI address-channel handshake
// Options  : define STRIDED_ADDR_GEN_4K_SPLIT_EN to split bursts at 4 KiB
//            boundaries; without it bursts may cross 4 KiB.
// Revision : 1.0 - initial release
// ============================================================================
module strided_address_generator #(
    parameter int ADDR_WIDTH            = 32,
    parameter int ID_WIDTH              = 8,
    parameter int MAX_AxLEN             = 15,
    parameter int AxSIZE_BYTES_PER_BEAT = 3,
    parameter int COUNT_WIDTH           = 16
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   done,
    input  logic [ADDR_WIDTH-1:0]  startAddr,
    input  logic [ADDR_WIDTH-1:0]  lineStride,
    input  logic [COUNT_WIDTH-1:0] lineBeats,
    input  logic [COUNT_WIDTH-1:0] lineCount,
    output logic [ID_WIDTH-1:0]    axid,
    output logic [ADDR_WIDTH-1:0]  axaddr,
    output logic [7:0]             axlen,
    output logic [2:0]             axsize,
    output logic [1:0]             axburst,
    output logic                   axlock,
    output logic [3:0]             axcache,
    output logic [2:0]             axprot,
    output logic                   axvalid,
    input  logic                   axready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam int BURST_MAX = MAX_AxLEN + 1;
    // Comparison width wide enough for the beat counter and the 4 KiB limit.
    localparam int CMP_W = (COUNT_WIDTH > 13) ? COUNT_WIDTH : 13;
    // Clears the sub-beat address bits so every burst is beat aligned.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << AxSIZE_BYTES_PER_BEAT;

    state_t                 state_q, state_d;
    logic                   done_q, done_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]  line_start_q, line_start_d;
    logic [ADDR_WIDTH-1:0]  stride_q, stride_d;
    logic [COUNT_WIDTH-1:0] line_beats_q, line_beats_d;
    logic [COUNT_WIDTH-1:0] beats_left_q, beats_left_d;
    logic [COUNT_WIDTH-1:0] lines_left_q, lines_left_d;
    logic [8:0]             burst_beats_q, burst_beats_d;
    logic [ID_WIDTH-1:0]    axid_q, axid_d;
    logic [ADDR_WIDTH-1:0]  axaddr_q, axaddr_d;
    logic [7:0]             axlen_q, axlen_d;
    logic                   axvalid_q, axvalid_d;

    // Beat count of the next burst: min(remaining, BURST_MAX[, 4 KiB limit]).
    logic [CMP_W-1:0] w_beats_wide;
    logic [8:0]       w_beats;

    always_comb begin
        w_beats_wide = CMP_W'(beats_left_q);
        if (w_beats_wide > CMP_W'(BURST_MAX)) begin
            w_beats_wide = CMP_W'(BURST_MAX);
        end
`ifdef STRIDED_ADDR_GEN_4K_SPLIT_EN
        begin : g_4k_limit
            logic [12:0] w_to_boundary;
            // Address is beat aligned, so the limit is always at least one beat.
            w_to_boundary = (13'h1000 - {1'b0, addr_q[11:0]}) >> AxSIZE_BYTES_PER_BEAT;
            if (w_beats_wide > CMP_W'(w_to_boundary)) begin
                w_beats_wide = CMP_W'(w_to_boundary);
            end
        end
`endif
        w_beats = w_beats_wide[8:0];
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        line_start_d  = line_start_q;
        stride_d      = stride_q;
        line_beats_d  = line_beats_q;
        beats_left_d  = beats_left_q;
        lines_left_d  = lines_left_q;
        burst_beats_d = burst_beats_q;
        axid_d        = axid_q;
        axaddr_d      = axaddr_q;
        axlen_d       = axlen_q;
        axvalid_d     = axvalid_q;

        case (state_q)
            IDLE: begin
                // Empty jobs are dropped without leaving IDLE.
                if (start && (lineBeats != '0) && (lineCount != '0)) begin
                    addr_d       = startAddr & ALIGN_MASK;
                    line_start_d = startAddr & ALIGN_MASK;
                    stride_d     = lineStride & ALIGN_MASK;
                    line_beats_d = lineBeats;
                    beats_left_d = lineBeats;
                    lines_left_d = lineCount;
                    axid_d       = '0;
                    state_d      = CALC;
                end
            end
            CALC: begin
                axaddr_d      = addr_q;
                burst_beats_d = w_beats;
                axlen_d       = 8'(w_beats - 9'd1);
                axvalid_d     = 1'b1;
                state_d       = ISSUE;
            end
            ISSUE: begin
                if (axready) begin
                    axvalid_d = 1'b0;
                    axid_d    = axid_q + 1'b1;
                    if (beats_left_q == COUNT_WIDTH'(burst_beats_q)) begin
                        if (lines_left_q == COUNT_WIDTH'(1)) begin
                            beats_left_d = '0;
                            lines_left_d = '0;
                            state_d      = IDLE;
                        end else begin
                            // Next line starts from the previous line start, not
                            // from where the running address ended.
                            line_start_d = line_start_q + stride_q;
                            addr_d       = line_start_q + stride_q;
                            beats_left_d = line_beats_q;
                            lines_left_d = lines_left_q - 1'b1;
                            state_d      = CALC;
                        end
                    end else begin
                        addr_d       = addr_q + (ADDR_WIDTH'(burst_beats_q) << AxSIZE_BYTES_PER_BEAT);
                        beats_left_d = beats_left_q - COUNT_WIDTH'(burst_beats_q);
                        state_d      = CALC;
                    end
                end
            end
            default: begin
                axvalid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase

        done_d = (state_d == IDLE);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q       <= IDLE;
            done_q        <= 1'b1;
            addr_q        <= '0;
            line_start_q  <= '0;
            stride_q      <= '0;
            line_beats_q  <= '0;
            beats_left_q  <= '0;
            lines_left_q  <= '0;
            burst_beats_q <= '0;
            axid_q        <= '0;
            axaddr_q      <= '0;
            axlen_q       <= 8'(MAX_AxLEN);
            axvalid_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            addr_q        <= addr_d;
            line_start_q  <= line_start_d;
            stride_q      <= stride_d;
            line_beats_q  <= line_beats_d;
            beats_left_q  <= beats_left_d;
            lines_left_q  <= lines_left_d;
            burst_beats_q <= burst_beats_d;
            axid_q        <= axid_d;
            axaddr_q      <= axaddr_d;
            axlen_q       <= axlen_d;
            axvalid_q     <= axvalid_d;
        end
    end

    assign done    = done_q;
    assign axid    = axid_q;
    assign axaddr  = axaddr_q;
    assign axlen   = axlen_q;
    assign axvalid = axvalid_q;
    assign axsize  = 3'(AxSIZE_BYTES_PER_BEAT);
    assign axburst = 2'b01;
    assign axlock  = 1'b0;
    assign axcache = 4'b0000;
    assign axprot  = 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_strided_address_generator.sv
`default_nettype none
// ============================================================================
// Module   : tb_strided_address_generator
// Purpose  : Directed self-checking bench for strided_address_generator with
//            default parameters (ADDR 32, ID 8, MAX_AxLEN 15, 8-byte beats).
// Revision : 1.0 - initial release
// ============================================================================
module tb_strided_address_generator;

    logic        aclk = 1'b0;
    logic        reset;
    logic        start;
    logic        done;
    logic [31:0] startAddr;
    logic [31:0] lineStride;
    logic [15:0] lineBeats;
    logic [15:0] lineCount;
    logic [7:0]  axid;
    logic [31:0] axaddr;
    logic [7:0]  axlen;
    logic [2:0]  axsize;
    logic [1:0]  axburst;
    logic        axlock;
    logic [3:0]  axcache;
    logic [2:0]  axprot;
    logic        axvalid;
    logic        axready;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    strided_address_generator dut (
        .aclk       (aclk),
        .reset      (reset),
        .start      (start),
        .done       (done),
        .startAddr  (startAddr),
        .lineStride (lineStride),
        .lineBeats  (lineBeats),
        .lineCount  (lineCount),
        .axid       (axid),
        .axaddr     (axaddr),
        .axlen      (axlen),
        .axsize     (axsize),
        .axburst    (axburst),
        .axlock     (axlock),
        .axcache    (axcache),
        .axprot     (axprot),
        .axvalid    (axvalid),
        .axready    (axready)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Launch a job: start is held over exactly one sampling edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] s,
                          input logic [15:0] b, input logic [15:0] c);
        startAddr  = a;
        lineStride = s;
        lineBeats  = b;
        lineCount  = c;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Wait (bounded) for axvalid, check the payload, then let axready=1 complete it.
    task automatic expect_burst(input string tag, input logic [31:0] a,
                                input logic [7:0] l, input logic [7:0] id);
        for (int i = 0; i < 20 && axvalid !== 1'b1; i++) tick();
        check({tag, " valid"}, 64'(axvalid), 64'd1);
        check({tag, " addr"},  64'(axaddr),  64'(a));
        check({tag, " len"},   64'(axlen),   64'(l));
        check({tag, " id"},    64'(axid),    64'(id));
        tick();
        check({tag, " gap"},   64'(axvalid), 64'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        startAddr  = '0;
        lineStride = '0;
        lineBeats  = '0;
        lineCount  = '0;
        axready    = 1'b1;
        tick();
        tick();

        // Reset state and constant outputs
        check("rst done",    64'(done),    64'd1);
        check("rst valid",   64'(axvalid), 64'd0);
        check("rst id",      64'(axid),    64'd0);
        check("rst addr",    64'(axaddr),  64'd0);
        check("rst len",     64'(axlen),   64'd15);
        check("rst size",    64'(axsize),  64'd3);
        check("rst burst",   64'(axburst), 64'd1);
        check("rst lock",    64'(axlock),  64'd0);
        check("rst cache",   64'(axcache), 64'd0);
        check("rst prot",    64'(axprot),  64'd0);
        reset = 1'b0;
        tick();

        // One line of 32 beats split into two max bursts; exact timing checked.
        launch(32'h1000, 32'h0, 16'd32, 16'd1);
        check("j1 busy",     64'(done),    64'd0);
        check("j1 calc",     64'(axvalid), 64'd0);
        tick();
        check("j1 b0 valid", 64'(axvalid), 64'd1);
        check("j1 b0 addr",  64'(axaddr),  64'h1000);
        check("j1 b0 len",   64'(axlen),   64'd15);
        check("j1 b0 id",    64'(axid),    64'd0);
        tick();
        check("j1 gap",      64'(axvalid), 64'd0);
        check("j1 gap busy", 64'(done),    64'd0);
        tick();
        check("j1 b1 valid", 64'(axvalid), 64'd1);
        check("j1 b1 addr",  64'(axaddr),  64'h1080);
        check("j1 b1 len",   64'(axlen),   64'd15);
        check("j1 b1 id",    64'(axid),    64'd1);
        tick();
        check("j1 end valid", 64'(axvalid), 64'd0);
        check("j1 done",      64'(done),    64'd1);

        // Two lines of 20 beats, stride 0x400; a mid-job start must be ignored.
        launch(32'h0, 32'h400, 16'd20, 16'd2);
        startAddr = 32'h5000;
        lineBeats = 16'd1;
        start     = 1'b1;
        expect_burst("j2 b0", 32'h000, 8'd15, 8'd0);
        start     = 1'b0;
        expect_burst("j2 b1", 32'h080, 8'd3,  8'd1);
        expect_burst("j2 b2", 32'h400, 8'd15, 8'd2);
        expect_burst("j2 b3", 32'h480, 8'd3,  8'd3);
        check("j2 done", 64'(done), 64'd1);

        // Backpressure: payload held while axready=0 for five cycles.
        axready = 1'b0;
        launch(32'h2000, 32'h0, 16'd8, 16'd1);
        tick();
        check("j3 valid", 64'(axvalid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("j3 hold valid", 64'(axvalid), 64'd1);
            check("j3 hold addr",  64'(axaddr),  64'h2000);
            check("j3 hold len",   64'(axlen),   64'd7);
            check("j3 hold id",    64'(axid),    64'd0);
        end
        axready = 1'b1;
        tick();
        check("j3 end valid", 64'(axvalid), 64'd0);
        check("j3 done",      64'(done),    64'd1);

        // 4 KiB boundary handling
        launch(32'hFC0, 32'h0, 16'd16, 16'd1);
`ifdef STRIDED_ADDR_GEN_4K_SPLIT_EN
        expect_burst("4k b0", 32'hFC0,  8'd7, 8'd0);
        expect_burst("4k b1", 32'h1000, 8'd7, 8'd1);
`else
        expect_burst("4k b0", 32'hFC0,  8'd15, 8'd0);
`endif
        check("4k done", 64'(done), 64'd1);

        // Address wrap past all-ones
        launch(32'hFFFF_FFC0, 32'h0, 16'd16, 16'd1);
`ifdef STRIDED_ADDR_GEN_4K_SPLIT_EN
        expect_burst("wrap b0", 32'hFFFF_FFC0, 8'd7, 8'd0);
        expect_burst("wrap b1", 32'h0,         8'd7, 8'd1);
`else
        expect_burst("wrap b0", 32'hFFFF_FFC0, 8'd15, 8'd0);
`endif
        check("wrap done", 64'(done), 64'd1);

        // Sub-beat bits of startAddr and lineStride are ignored.
        launch(32'h5, 32'h107, 16'd1, 16'd2);
        expect_burst("align b0", 32'h000, 8'd0, 8'd0);
        expect_burst("align b1", 32'h100, 8'd0, 8'd1);
        check("align done", 64'(done), 64'd1);

        // Empty jobs issue nothing.
        launch(32'h3000, 32'h0, 16'd4, 16'd0);
        check("cnt0 done",  64'(done),    64'd1);
        tick();
        check("cnt0 valid", 64'(axvalid), 64'd0);
        launch(32'h3000, 32'h0, 16'd0, 16'd4);
        check("beat0 done", 64'(done),    64'd1);
        tick();
        check("beat0 valid", 64'(axvalid), 64'd0);

        // Reset during an outstanding burst abandons the job.
        axready = 1'b0;
        launch(32'h3000, 32'h0, 16'd16, 16'd1);
        tick();
        check("mid valid", 64'(axvalid), 64'd1);
        reset = 1'b1;
        tick();
        check("mid rst valid", 64'(axvalid), 64'd0);
        check("mid rst done",  64'(done),    64'd1);
        check("mid rst id",    64'(axid),    64'd0);
        check("mid rst addr",  64'(axaddr),  64'd0);
        check("mid rst len",   64'(axlen),   64'd15);
        reset   = 1'b0;
        axready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post rst valid", 64'(axvalid), 64'd0);
        end
        check("post rst done", 64'(done), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
